nes_controller_ports: RTL
=========================

Name: nes_controller_ports

Overview:
Parametrised, cycle-accurate standard-controller interface at CPU addresses $4016/$4017. It replaces the single-port, start-button-only read sequencer inside the CPU memory map. It implements the strobe latch and per-port serial shift registers, supports up to two ports of configurable button width, and drives open-bus upper bits. It sits beside cpu_memory on the CPU bus; cpu_memory muxes r_data in whenever ctl_hit was asserted on the previous enabled cycle.

Parameters:
NUM_PORTS, 2, number of controller ports (1 or 2); port p is read at $4016+p.
BUTTONS, 8, bits per port shift register (1..16).
OPEN_BUS, 8'h40, value driven on r_data[7:1] for controller reads.
FILL_BIT, 1'b1, bit shifted into the MSB on each serial read; returned after BUTTONS reads.

Ports:
clock  input  1  system clock
reset_n  input  1  synchronous, active-low reset
clock_en  input  1  CPU cycle enable; all state updates only when high
addr  input  16  CPU bus address
r_en  input  1  1 = read, 0 = write (same encoding as cpu_memory)
w_data  input  8  CPU write data
buttons  input  NUM_PORTS*BUTTONS  live button levels, 1 = pressed; port p at [p*BUTTONS +: BUTTONS], bit 0 = A, 1 = B, 2 = Select, 3 = Start, 4 = Up, 5 = Down, 6 = Left, 7 = Right
ctl_hit  output  1  combinational: read access to an implemented controller address this cycle
r_data  output  8  registered read data
rd_valid  output  1  registered: r_data holds a controller read result
strobe  output  1  current strobe latch value (debug/LED)

Behaviour:
- Interface: clock and reset_n; reset is synchronous and active-low, sampled on posedge clock, and takes priority over clock_en.
- Reset values: strobe = 0, every shift register = all FILL_BIT, every read counter = BUTTONS, r_data = 8'h00, rd_valid = 0.
- Access: one bus access per clock_en cycle. A write is r_en = 0; a read is r_en = 1. Non-matching addresses cause no state change.
- Strobe write: a write to $4016 sets strobe <= w_data[0], effective from the next enabled cycle. Writes to $4017 are ignored because that address is the APU frame counter.
- Reload: each enabled cycle with strobe = 1 (registered value), every port does shift_reg <= buttons slice and counter <= 0.
- Strobe 1->0: the last loaded snapshot is held, and serial reads begin from bit 0.
- ctl_hit = r_en & (addr == 16'h4016 | (addr == 16'h4017 & NUM_PORTS == 2)).
- Read latency: one enabled cycle. On a read cycle r_data <= {OPEN_BUS[7:1], bit} and rd_valid <= 1.
  - With strobe = 1, bit = live buttons bit 0 (A) of that port. No shift, no counter change.
  - With strobe = 0, bit = shift_reg[0]. Then shift_reg <= {FILL_BIT, shift_reg[BUTTONS-1:1]} and counter <= min(counter + 1, BUTTONS), saturating.
- Other enabled cycles: rd_valid <= 0 and r_data holds.
- Enabled cycle with strobe = 1 and a read: the reload still occurs; the read returns live A.
- Write to $4016 with w_data[0] = 1 mid-sequence: the next cycle reloads. Any partial sequence is abandoned; no error is raised.
- Overrun: more than BUTTONS reads return FILL_BIT indefinitely; the counter stays at BUTTONS.
- NUM_PORTS = 1: $4017 does not hit, and r_data/rd_valid are unaffected.
- Port independence: reading port 0 never shifts port 1, and vice versa.
- clock_en = 0: all registers hold, including strobe; the buttons input is not sampled.
- Reset mid-sequence: all registers return to reset values within the same cycle.

Test Plan:
- Reset, then read $4016 eight times without strobe -> each read gives r_data = 8'h41 with rd_valid = 1 one enabled cycle later.
- Port 0 buttons = 8'b0000_1001 (A + Start). Write $4016 = 1, then $4016 = 0, then read $4016 ×10 -> bit sequence 1,0,0,1,0,0,0,0,1,1; r_data values 8'h41,8'h40,8'h40,8'h41,8'h40,8'h40,8'h40,8'h40,8'h41,8'h41.
- Strobe held at 1, buttons toggled A 0->1->0 between reads -> reads follow live A (8'h40, 8'h41, 8'h40); no shifting observed after strobe drops.
- Both ports: port 0 = 8'hFF, port 1 = 8'h02; strobe, then interleave reads $4016, $4017 ×3 -> port 0 gives 1,1,1; port 1 gives 0,1,0; no cross-shift.
- Re-strobe after 3 reads with new buttons, plus clock_en low for 4 cycles mid-sequence -> sequence restarts at new bit 0; no state advances while clock_en = 0; a write to $4017 changes nothing.
- reset_n low for one cycle mid-sequence, including one cycle with clock_en = 0 -> strobe = 0, rd_valid = 0, r_data = 0; the next reads return FILL_BIT (8'h41).

Source files
------------

// File: rtl/nes_controller_ports.sv
`default_nettype none
// ============================================================================
//  Module      : nes_controller_ports
//  Description : Standard-controller interface at CPU $4016/$4017. Holds the
//                strobe latch and one serial shift register plus saturating
//                read counter per port. Reads return one button bit in
//                r_data[0] with open-bus bits above it, one enabled cycle
//                after the access.
//  Ports       : clock, reset_n (sync, active-low), clock_en (CPU cycle
//                enable), addr/r_en/w_data (CPU bus), buttons (live levels,
//                port p at [p*BUTTONS +: BUTTONS]), ctl_hit (comb hit),
//                r_data/rd_valid (registered read result), strobe (latch).
//  Revision    : 1.0 - initial release
// ============================================================================
module nes_controller_ports #(
    parameter int          NUM_PORTS = 2,
    parameter int          BUTTONS   = 8,
    parameter logic [7:0]  OPEN_BUS  = 8'h40,
    parameter logic        FILL_BIT  = 1'b1
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           clock_en,
    input  logic [15:0]                    addr,
    input  logic                           r_en,
    input  logic [7:0]                     w_data,
    input  logic [NUM_PORTS*BUTTONS-1:0]   buttons,
    output logic                           ctl_hit,
    output logic [7:0]                     r_data,
    output logic                           rd_valid,
    output logic                           strobe
);

    localparam int               c_CW      = $clog2(BUTTONS + 1);
    localparam logic [c_CW-1:0]  c_CNT_MAX = c_CW'(BUTTONS);
    localparam logic [15:0]      c_BASE    = 16'h4016;

    logic                  strobe_q;
    logic [7:0]            r_data_q;
    logic                  rd_valid_q;

    // One-hot read select per port and the bit each port would return.
    logic [NUM_PORTS-1:0]  w_sel;
    logic [NUM_PORTS-1:0]  w_bit;
    logic                  w_rd_bit;
    logic                  w_wr_strobe;

    // $4017 writes belong to the APU frame counter, so only $4016 latches.
    assign w_wr_strobe = ~r_en & (addr == c_BASE);
    assign ctl_hit     = |w_sel;
    assign w_rd_bit    = |(w_sel & w_bit);

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            logic [BUTTONS-1:0] sr_q;
            logic [BUTTONS-1:0] sr_d;
            logic [c_CW-1:0]    cnt_q;
            logic [c_CW-1:0]    cnt_d;

            assign w_sel[p] = r_en & (addr == (c_BASE + 16'(p)));

            // While strobed the port is transparent: reads see live A.
            assign w_bit[p] = strobe_q ? buttons[p*BUTTONS] : sr_q[0];

            always_comb begin
                sr_d  = sr_q;
                cnt_d = cnt_q;
                if (strobe_q) begin
                    sr_d  = buttons[p*BUTTONS +: BUTTONS];
                    cnt_d = '0;
                end else if (w_sel[p]) begin
                    // Shift toward bit 0, refilling the MSB so overrun
                    // reads keep returning FILL_BIT.
                    sr_d = (sr_q >> 1) | (BUTTONS'(FILL_BIT) << (BUTTONS - 1));
                    if (cnt_q != c_CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    sr_q  <= {BUTTONS{FILL_BIT}};
                    cnt_q <= c_CNT_MAX;
                end else if (clock_en) begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            strobe_q   <= 1'b0;
            r_data_q   <= 8'h00;
            rd_valid_q <= 1'b0;
        end else if (clock_en) begin
            if (w_wr_strobe) begin
                strobe_q <= w_data[0];
            end
            if (ctl_hit) begin
                r_data_q   <= {OPEN_BUS[7:1], w_rd_bit};
                rd_valid_q <= 1'b1;
            end else begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    assign r_data   = r_data_q;
    assign rd_valid = rd_valid_q;
    assign strobe   = strobe_q;

endmodule
`default_nettype wire
